// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the big-endian instruction memory: header, payload, XOR checksum.
// Holds the core in reset until a complete image has been written and verified.
//
// state    | meaning
// S_IDLE   | waiting for start, nothing loaded
// S_HDR_HI | expecting word count bits 15:8
// S_HDR_LO | expecting word count bits 7:0, size check
// S_LOAD   | writing payload bytes to memory
// S_CHK    | expecting checksum byte
// S_DONE   | image loaded and verified, core released
// S_ERR    | image too large or checksum mismatch
module instr_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic [15:0] words_loaded_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_rst_n_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_LOAD, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [32:0] ROOM = 33'(MEM_BYTES) - {1'b0, BASE_ADDR};

    state_t      state_q;
    logic [15:0] n_q;
    logic [17:0] off_q;
    logic [7:0]  acc_q;
    logic        in_ready_q, mem_we_q, busy_q, done_q, error_q, cpu_rst_n_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic [15:0] words_q;

    logic        xfer_d;
    logic [15:0] n_d;
    logic        oversize_d;

    assign xfer_d     = in_valid_i && in_ready_q;
    assign n_d        = {n_q[15:8], in_data_i};
    // 4*N evaluated wide enough that N=16'hFFFF cannot wrap below the room
    assign oversize_d = {15'b0, n_d, 2'b00} > ROOM;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            off_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            words_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q    <= S_HDR_HI;
                        off_q      <= '0;
                        words_q    <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end else if (state_q == S_DONE) begin
                        cpu_rst_n_q <= 1'b1;
                    end
                end
                S_HDR_HI: begin
                    if (xfer_d) begin
                        n_q[15:8] <= in_data_i;
                        state_q   <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer_d) begin
                        n_q <= n_d;
                        if (oversize_d) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else if (n_d == 16'd0) begin
                            state_q <= S_CHK;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer_d) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + 32'(off_q);
                        mem_wdata_q <= in_data_i;
                        acc_q       <= acc_q ^ in_data_i;
                        off_q       <= off_q + 18'd1;
                        if (off_q[1:0] == 2'b11) begin
                            words_q <= words_q + 16'd1;
                        end
                        if (off_q + 18'd1 == {n_q, 2'b00}) begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (xfer_d) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_data_i == acc_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o     = in_ready_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign words_loaded_o = words_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign cpu_rst_n_o    = cpu_rst_n_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader; images are built as 32-bit words
// and the expected byte writes, checksum and outcome are derived from them.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, busy, done, error, cpu_rst_n;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         obs[$];
    logic [31:0] img[$];
    logic [7:0]  mem [0:1023];

    instr_mem_loader #(.BASE_ADDR(32'h0), .MEM_BYTES(1024)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .words_loaded_o(words_loaded), .busy_o(busy), .done_o(done),
        .error_o(error), .cpu_rst_n_o(cpu_rst_n)
    );

    always #5 clk = ~clk;

    // target memory stand-in plus a log of every strobe
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs.push_back('{a: mem_addr, d: mem_wdata});
            if (mem_addr < 32'd1024) mem[mem_addr[9:0]] = mem_wdata;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] img_byte(input int k);
        logic [31:0] w;
        w = img[k / 4];
        return 8'(w >> (24 - 8 * (k % 4)));
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit wr, input int k);
        int t;
        while (gap > 0 && int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("stall_we", 32'(mem_we), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (wr) begin
            chk("we_latency", 32'(mem_we), 32'd1);
            chk("wr_addr", mem_addr, 32'(k));
            chk("wr_data", 32'(mem_wdata), 32'(b));
            chk("words_progress", 32'(words_loaded), 32'((k + 1) / 4));
        end
    endtask

    task automatic do_load(input int n, input logic [7:0] flip, input int gap, input bit mid_start);
        logic [7:0] acc;
        logic [15:0] nh;
        int bad;
        bit fits;
        acc  = 8'h00;
        nh   = 16'(n);
        fits = (4 * n <= 1024);
        obs.delete();
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst_n), 32'd0);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_words_clr", 32'(words_loaded), 32'd0);
        send(nh[15:8], 0, 1'b0, 0);
        send(nh[7:0], 0, 1'b0, 0);
        if (!fits) begin
            @(negedge clk); #1;
            chk("ovf_error", 32'(error), 32'd1);
            chk("ovf_done", 32'(done), 32'd0);
            chk("ovf_busy", 32'(busy), 32'd0);
            chk("ovf_ready", 32'(in_ready), 32'd0);
            chk("ovf_writes", 32'(obs.size()), 32'd0);
            return;
        end
        for (int k = 0; k < 4 * n; k++) begin
            if (mid_start && k == 2) begin
                pulse_start();
                chk("busy_start_ignored", 32'(busy), 32'd1);
                chk("busy_start_no_we", 32'(mem_we), 32'd0);
            end
            acc ^= img_byte(k);
            send(img_byte(k), gap, 1'b1, k);
        end
        send(acc ^ flip, gap, 1'b0, 0);
        @(negedge clk); #1;
        chk("end_done", 32'(done), 32'(flip == 8'h00));
        chk("end_error", 32'(error), 32'(flip != 8'h00));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_words", 32'(words_loaded), 32'(n));
        chk("end_n_writes", 32'(obs.size()), 32'(4 * n));
        bad = 0;
        for (int i = 0; i < obs.size(); i++)
            if (obs[i].a !== 32'(i) || obs[i].d !== img_byte(i)) bad++;
        chk("write_sequence", 32'(bad), 32'd0);
        bad = 0;
        for (int w = 0; w < n; w++)
            if ({mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]} !== img[w]) bad++;
        chk("readback", 32'(bad), 32'd0);
        @(negedge clk);
        chk("end_cpu_rst", 32'(cpu_rst_n), 32'(flip == 8'h00));
    endtask

    initial begin
        // reset held for two cycles
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // two-word image, good then corrupted checksum
        img = '{32'h13000093, 32'h0050006F};
        do_load(2, 8'h00, 0, 1'b0);
        do_load(2, 8'h01, 0, 1'b0);

        // size boundary: one word too many, then exactly full
        do_load(257, 8'h00, 0, 1'b0);
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back($urandom);
        do_load(256, 8'h00, 0, 1'b0);

        // stalls on the stream must not change the write sequence
        img = '{32'h13000093, 32'h0050006F};
        do_load(2, 8'h00, 50, 1'b0);

        // reset after five payload bytes
        obs.delete();
        pulse_start();
        send(8'h00, 0, 1'b0, 0);
        send(8'h02, 0, 1'b0, 0);
        for (int k = 0; k < 5; k++) send(img_byte(k), 0, 1'b1, k);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_idle_ready", 32'(in_ready), 32'd0);
        chk("abort_n_writes", 32'(obs.size()), 32'd5);
        in_valid = 1'b0;

        // empty image, then restart from DONE with a start pulse mid-load
        do_load(0, 8'h00, 0, 1'b0);
        do_load(2, 8'h00, 0, 1'b1);

        // randomized images
        for (int r = 0; r < 5; r++) begin
            int n;
            logic [7:0] flip;
            n = int'($urandom_range(1, 20));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            flip = ($urandom_range(1) == 0) ? 8'h00 : 8'(1 << $urandom_range(7));
            do_load(n, flip, int'($urandom_range(60)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
